// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   mdu_op_e    : operation encodings driven on op_i
//   mdu_state_e : sequencer states
//   cnt_width() : iteration counter width for an N-bit datapath
package mdu_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'd0,
        MDU_MULTU = 2'd1,
        MDU_DIV   = 2'd2,
        MDU_DIVU  = 2'd3
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FIXUP = 2'd2
    } mdu_state_e;

    // Counter must hold the value N itself, hence the extra bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return $clog2(n) + 1;
    endfunction

    localparam int unsigned MDU_CNT_W = cnt_width(32);

endpackage

// File: rtl/mult_div_unit_cond_negate.sv
// Conditional two's-complement negate, chainable for wider words.
//   a    : input word
//   neg  : invert a when set
//   cin  : increment carry-in (neg for a standalone negate, the lower
//          slice's cout for the upper slice of a chained negate)
//   y    : (neg ? ~a : a) + cin
//   cout : carry out of the increment
module cond_negate #(
    parameter int unsigned N = 32
) (
    input  logic [N-1:0] a,
    input  logic         neg,
    input  logic         cin,
    output logic [N-1:0] y,
    output logic         cout
);

    always_comb begin
        {cout, y} = {1'b0, a ^ {N{neg}}} + {{N{1'b0}}, cin};
    end

endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit producing the HI/LO pair for
// MULT, MULTU, DIV and DIVU, plus MTHI/MTLO register writes.
//   clk, reset           : clock, synchronous active-high reset
//   start_i, op_i        : launch request and operation (accepted in IDLE)
//   rs_data_i, rt_data_i : operands A and B; rs_data_i also feeds MTHI/MTLO
//   mthi_i, mtlo_i       : write rs_data_i to HI / LO (IDLE only)
//   hi_o, lo_o           : result registers
//   busy_o, done_o       : operation in flight / one-cycle completion pulse
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start_i,
    input  logic [1:0]   op_i,
    input  logic [N-1:0] rs_data_i,
    input  logic [N-1:0] rt_data_i,
    input  logic         mthi_i,
    input  logic         mtlo_i,
    output logic [N-1:0] hi_o,
    output logic [N-1:0] lo_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned CW = cnt_width(N);

    mdu_state_e     state, state_nxt;
    mdu_op_e        op_sel;
    logic [CW-1:0]  cnt;
    logic [2*N-1:0] acc;
    logic [N-1:0]   opb;
    logic           op_div, res_neg, rem_neg, div_zero;
    logic [N-1:0]   hi_q, lo_q;
    logic           done_q;

    logic           signed_op, neg_a, neg_b;
    logic [N-1:0]   mag_a, mag_b, fix_lo, fix_hi;
    logic           c_a, c_b, c_lo, c_hi;
    logic           unused_carries;

    logic [N:0]     add_sum, trial;
    logic [2*N-1:0] mul_next, div_next;

    assign op_sel    = mdu_op_e'(op_i);
    assign signed_op = (op_sel == MDU_MULT) || (op_sel == MDU_DIV);
    assign neg_a     = signed_op & rs_data_i[N-1];
    assign neg_b     = signed_op & rt_data_i[N-1];

    cond_negate #(.N(N)) u_abs_a (
        .a(rs_data_i), .neg(neg_a), .cin(neg_a), .y(mag_a), .cout(c_a)
    );

    cond_negate #(.N(N)) u_abs_b (
        .a(rt_data_i), .neg(neg_b), .cin(neg_b), .y(mag_b), .cout(c_b)
    );

    // Low half negates quotient or product-low. High half is either the
    // upper slice of the 2N-bit product negate (carry chained from the low
    // half) or an independent remainder negate.
    cond_negate #(.N(N)) u_fix_lo (
        .a(acc[N-1:0]), .neg(res_neg), .cin(res_neg), .y(fix_lo), .cout(c_lo)
    );

    cond_negate #(.N(N)) u_fix_hi (
        .a(acc[2*N-1:N]),
        .neg(op_div ? rem_neg : res_neg),
        .cin(op_div ? rem_neg : c_lo),
        .y(fix_hi),
        .cout(c_hi)
    );

    assign unused_carries = c_a | c_b | c_hi;

    // Multiply: product builds in the top half while the multiplier
    // shifts out of the bottom, LSB first.
    always_comb begin
        add_sum  = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opb} : '0);
        mul_next = {add_sum, acc[N-1:1]};
    end

    // Divide: restoring step on the shifted remainder; a zero divisor
    // never borrows, leaving the dividend magnitude as remainder.
    always_comb begin
        trial    = acc[2*N-1:N-1] - {1'b0, opb};
        div_next = trial[N] ? {acc[2*N-2:0], 1'b0}
                            : {trial[N-1:0], acc[N-2:0], 1'b1};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = RUN;
            RUN:     if (cnt == CW'(1)) state_nxt = FIXUP;
            FIXUP:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            opb      <= '0;
            op_div   <= 1'b0;
            res_neg  <= 1'b0;
            rem_neg  <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= (state == FIXUP);
            case (state)
                IDLE: begin
                    if (start_i) begin
                        op_div   <= op_i[1];
                        res_neg  <= neg_a ^ neg_b;
                        rem_neg  <= neg_a;
                        div_zero <= (rt_data_i == '0);
                        cnt      <= CW'(N);
                        acc      <= op_i[1] ? {{N{1'b0}}, mag_a} : {{N{1'b0}}, mag_b};
                        opb      <= op_i[1] ? mag_b : mag_a;
                    end else begin
                        if (mthi_i) hi_q <= rs_data_i;
                        if (mtlo_i) lo_q <= rs_data_i;
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    acc <= op_div ? div_next : mul_next;
                end
                FIXUP: begin
                    hi_q <= fix_hi;
                    lo_q <= (op_div && div_zero) ? '1 : fix_lo;
                end
                default: ;
            endcase
        end
    end

    assign hi_o   = hi_q;
    assign lo_o   = lo_q;
    assign busy_o = (state != IDLE);
    assign done_o = done_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit (N = 32).
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [1:0]  op_i = 2'd0;
    logic [31:0] rs_data_i = '0;
    logic [31:0] rt_data_i = '0;
    logic        mthi_i = 1'b0;
    logic        mtlo_i = 1'b0;
    logic [31:0] hi_o, lo_o;
    logic        busy_o, done_o;

    int total = 0;
    int bad   = 0;

    mult_div_unit #(.N(32)) dut (
        .clk(clk), .reset(reset), .start_i(start_i), .op_i(op_i),
        .rs_data_i(rs_data_i), .rt_data_i(rt_data_i),
        .mthi_i(mthi_i), .mtlo_i(mtlo_i),
        .hi_o(hi_o), .lo_o(lo_o), .busy_o(busy_o), .done_o(done_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch in cycle 0, follow busy until done (bounded), check latency,
    // busy/hold behaviour and the result. Returns in the done_o cycle.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic mtlo, input logic inject,
                          input logic [31:0] ehi, input logic [31:0] elo);
        logic [31:0] phi, plo;
        int cyc;
        logic busy_ok, hold_ok;
        phi = hi_o;
        plo = lo_o;
        start_i = 1'b1; op_i = op; rs_data_i = a; rt_data_i = b; mtlo_i = mtlo;
        tick();
        start_i = 1'b0; mtlo_i = 1'b0;
        cyc = 1; busy_ok = 1'b1; hold_ok = 1'b1;
        while (!done_o && cyc < 100) begin
            if (!busy_o) busy_ok = 1'b0;
            if (hi_o !== phi || lo_o !== plo) hold_ok = 1'b0;
            if (inject && cyc == 10) begin
                start_i = 1'b1; op_i = 2'd3; rs_data_i = 32'hDEAD; mthi_i = 1'b1;
            end
            tick();
            start_i = 1'b0; mthi_i = 1'b0;
            cyc++;
        end
        check_eq({tag, "_latency"}, 32'(cyc), 32'd34);
        check_eq({tag, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
        check_eq({tag, "_hold"}, {31'd0, hold_ok}, 32'd1);
        check_eq({tag, "_done"}, {31'd0, done_o}, 32'd1);
        check_eq({tag, "_busy_end"}, {31'd0, busy_o}, 32'd0);
        check_eq({tag, "_hi"}, hi_o, ehi);
        check_eq({tag, "_lo"}, lo_o, elo);
    endtask

    initial begin
        int pulses;
        int busy_seen;

        tick();
        tick();
        check_eq("rst_hi", hi_o, 32'd0);
        check_eq("rst_lo", lo_o, 32'd0);
        check_eq("rst_busy", {31'd0, busy_o}, 32'd0);
        check_eq("rst_done", {31'd0, done_o}, 32'd0);
        reset = 1'b0;
        tick();

        run_op("multu_max", 2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0,
               32'hFFFFFFFE, 32'h00000001);
        tick();
        check_eq("multu_done_width", {31'd0, done_o}, 32'd0);

        run_op("mult_neg", 2'd0, 32'hFFFFFFFD, 32'd5, 1'b0, 1'b0,
               32'hFFFFFFFF, 32'hFFFFFFF1);
        // Issued in the done cycle of the previous op.
        run_op("div_b2b", 2'd2, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0,
               32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu_zero", 2'd3, 32'd100, 32'd0, 1'b0, 1'b0,
               32'h00000064, 32'hFFFFFFFF);
        run_op("div_ovf", 2'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0,
               32'h00000000, 32'h80000000);
        tick();

        run_op("ignore_busy", 2'd1, 32'd6, 32'd7, 1'b0, 1'b1,
               32'd0, 32'd42);
        pulses = 0; busy_seen = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o) pulses++;
            if (busy_o) busy_seen++;
        end
        check_eq("ignore_extra_done", 32'(pulses), 32'd0);
        check_eq("ignore_no_restart", 32'(busy_seen), 32'd0);
        check_eq("ignore_hi", hi_o, 32'd0);

        // Reset asserted during cycle 15 of a divide.
        start_i = 1'b1; op_i = 2'd3; rs_data_i = 32'd1000; rt_data_i = 32'd3;
        tick();
        start_i = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_eq("abort_busy", {31'd0, busy_o}, 32'd0);
        check_eq("abort_hi", hi_o, 32'd0);
        check_eq("abort_lo", lo_o, 32'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            if (done_o) pulses++;
            tick();
        end
        check_eq("abort_no_done", 32'(pulses), 32'd0);
        run_op("divu_fresh", 2'd3, 32'd1000, 32'd3, 1'b0, 1'b0,
               32'd1, 32'd333);
        tick();

        mthi_i = 1'b1; rs_data_i = 32'h12345678;
        tick();
        mthi_i = 1'b0;
        check_eq("mthi", hi_o, 32'h12345678);
        mtlo_i = 1'b1; rs_data_i = 32'h9ABCDEF0;
        tick();
        mtlo_i = 1'b0;
        check_eq("mtlo", lo_o, 32'h9ABCDEF0);
        check_eq("mtlo_hi_kept", hi_o, 32'h12345678);
        mthi_i = 1'b1; mtlo_i = 1'b1; rs_data_i = 32'h000055AA;
        tick();
        mthi_i = 1'b0; mtlo_i = 1'b0;
        check_eq("mt_both_hi", hi_o, 32'h000055AA);
        check_eq("mt_both_lo", lo_o, 32'h000055AA);

        // MTLO in the start cycle must be dropped (hold check covers cycle 1).
        run_op("start_mtlo", 2'd1, 32'd2, 32'd3, 1'b1, 1'b0,
               32'd0, 32'd6);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit that consumes the two register-file read operands (R[rs], R[rt]) and produces the HI/LO result pair for MULT, MULTU, DIV and DIVU. It sits directly downstream of the register file, in parallel with the ALU in the execute stage. It is driven by a start/busy/done handshake so the control unit can stall on MFHI/MFLO. It also services MTHI/MTLO writes.

## Interface
- N, 32: operand width; must be even and ≥ 4.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start_i  in  1  launch the operation in op_i; sampled only in IDLE.
- op_i  in  2  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
- rs_data_i  in  N  operand A (multiplicand / dividend); also MTHI/MTLO data.
- rt_data_i  in  N  operand B (multiplier / divisor).
- mthi_i  in  1  write rs_data_i to HI; honoured only in IDLE.
- mtlo_i  in  1  write rs_data_i to LO; honoured only in IDLE.
- hi_o  out  N  HI register (product high half / remainder).
- lo_o  out  N  LO register (product low half / quotient).
- busy_o  out  1  high while an operation is in flight.
- done_o  out  1  one-cycle pulse in the cycle HI/LO first show the new result.

## Operation
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state IDLE, hi_o = 0, lo_o = 0, busy_o = 0, done_o = 0, iteration counter = 0.
- **IDLE**
  - start_i = 1: latch op_i, take the operand magnitudes, record the result sign, load counter = N, go to RUN.
  - Magnitude and sign handling: signed ops use |rs|, |rt|. Unsigned ops pass operands through with sign = 0.
  - mthi_i / mtlo_i: write the selected register(s). Both may be set together.
  - start_i and mthi_i/mtlo_i in the same cycle: start wins and the MT write is dropped.
- **RUN**: one iteration per cycle, counter decrements, leave for FIXUP when the counter reaches 0.
  - Multiply: shift-add into a 2N-bit accumulator, 1 multiplier bit per cycle, LSB first.
  - Divide: restoring shift-subtract into a 2N-bit remainder:quotient register, 1 quotient bit per cycle, MSB first.
- **FIXUP**: one cycle, then return to IDLE.
  - Multiply: negate the 2N-bit product if the sign flag is set; {HI, LO} ← product.
  - Divide: negate the quotient if the operand signs differ; the remainder takes the dividend's sign; LO ← quotient, HI ← remainder.
  - Sets done_o for the next cycle.
- **Divide by zero**: no trap, same latency. LO = all ones; HI = the dividend, unmodified.
- **Signed overflow** (0x8000_0000 / −1): LO = 0x8000_0000, HI = 0. This falls out of the magnitude arithmetic with no special case.
- start_i, mthi_i, mtlo_i are ignored while busy_o = 1. The hazard logic must stall instead.
- HI/LO hold their previous values throughout RUN and change only in FIXUP.
- Reset during RUN or FIXUP: abort immediately to reset values. No done_o pulse.

## Timing
- start_i accepted in cycle 0 → busy_o high in cycles 1…N+1 → done_o = 1, busy_o = 0 and new HI/LO visible in cycle N+2 (34 for N = 32).
- A new start_i is accepted in the same cycle done_o is high, so back-to-back operations run every N+2 cycles.
- MTHI/MTLO: the write lands on the edge ending cycle 0 and is visible in cycle 1.
- busy_o and done_o are registered (decoded from state registers only); no combinational path from inputs to outputs.

## Structure
- Shared package mdu_pkg holds:
  - op encodings: MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU;
  - state encoding: IDLE, RUN, FIXUP;
  - counter width constant $clog2(N)+1.
- One natural sub-module: cond_negate (N-parameterised conditional two's-complement). It is instantiated for operand abs-value and for the result/remainder fixup. The 2N product negate chains two instances with carry.
- Everything else stays in one file: state register, counter, accumulator datapath, HI/LO registers.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → cycle 34: HI = 0xFFFFFFFE, LO = 0x00000001, done_o one cycle; busy_o high cycles 1–33.
- MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1. DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 → LO = 0xFFFFFFFF, HI = 0x00000064. DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Hold and ignore while busy:
  - start MULTU 6 × 7, then pulse start_i (DIVU) and mthi_i (rs = 0xDEAD) at cycle 10;
  - HI/LO must hold the prior values until cycle 34;
  - then HI = 0, LO = 42, exactly one done_o.
- Reset at cycle 15 of DIVU 1000 / 3 → next cycle: busy_o = 0, HI = LO = 0, no done_o ever. A fresh DIVU then gives LO = 333, HI = 1.
- MT writes and back-to-back starts:
  - MTHI 0x12345678 with MTLO 0x9ABCDEF0 in IDLE → both visible the next cycle;
  - start_i and mtlo_i together → the MTLO write is dropped;
  - back-to-back start issued on the done_o cycle is accepted.
